score_tracker: RTL

Game-score stage that sits directly upstream of the seven-segment score display. Counts successful block placements reported by the stacker game logic and tracks the WIN/LOSE outcome. Keeps a session best score and takes a debounced restart button. Packs best and current level into the 8-bit score bus; the display stage renders the low nibble.

---
 rtl/score_tracker_pkg.sv | 18 +
 rtl/restart_debounce.sv | 41 ++++
 rtl/score_tracker.sv | 120 ++++++++++++
 3 files changed

// File: rtl/score_tracker_pkg.sv
// Shared types and constants for the stacker score stage.
package score_tracker_pkg;

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    WIN  = 2'd1,
    LOSE = 2'd2
  } game_state_t;

  localparam int LEVEL_W     = 4;
  localparam int BLINK_CNT_W = 22;

  function automatic logic [LEVEL_W-1:0] max_level(input logic [LEVEL_W-1:0] a,
                                                   input logic [LEVEL_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/restart_debounce.sv
// Synchronizes and debounces a raw push button and emits a one-cycle pulse
// when the debounced level rises.
module restart_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic [1:0]       sync_q;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  // The counter measures how long the synchronized input has disagreed with
  // the debounced level; any agreement (a bounce back) restarts the wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      stable <= 1'b0;
      cnt    <= '0;
      pulse  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn};
      pulse  <= 1'b0;
      if (sync_q[1] == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable <= sync_q[1];
        cnt    <= '0;
        pulse  <= sync_q[1];
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/score_tracker.sv
// Level/best score tracking, WIN/LOSE outcome and status LEDs for the
// stacker game; score packs {best, level} for the seven-segment stage.
module score_tracker
  import score_tracker_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int MAX_LEVEL       = 15,
  parameter int BLINK_W         = BLINK_CNT_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       place_valid,
  input  logic       place_hit,
  input  logic       restart_btn,
  output logic [7:0] score,
  output logic       game_over,
  output logic       game_won,
  output logic [7:0] led
);

  localparam logic [LEVEL_W-1:0] MAX_LVL = LEVEL_W'(MAX_LEVEL);

  game_state_t        state;
  logic [LEVEL_W-1:0] level;
  logic [LEVEL_W-1:0] best;
  logic [LEVEL_W-1:0] level_inc;
  logic [LEVEL_W-1:0] best_win;
  logic [LEVEL_W-1:0] best_lose;
  logic [BLINK_W:0]   blink_cnt;
  logic [BLINK_W:0]   blink_nxt;
  logic [7:0]         blink_led;
  logic               restart_pulse;

  restart_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_restart (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (restart_btn),
    .pulse(restart_pulse)
  );

  assign level_inc = level + LEVEL_W'(1);
  assign best_win  = max_level(best, level_inc);
  assign best_lose = max_level(best, level);
  assign blink_nxt = blink_cnt + (BLINK_W + 1)'(1);
  assign blink_led = {8{blink_nxt[BLINK_W]}};

  // Outputs are loaded from the same next-state values as the state
  // registers so they reflect an event one cycle after it is sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= PLAY;
      level     <= '0;
      best      <= '0;
      blink_cnt <= '0;
      score     <= 8'h00;
      game_over <= 1'b0;
      game_won  <= 1'b0;
      led       <= 8'h00;
    end else begin
      blink_cnt <= blink_nxt;
      unique case (state)
        PLAY: begin
          if (restart_pulse) begin
            level <= '0;
            score <= {best, 4'h0};
            led   <= 8'h00;
          end else if (place_valid && place_hit && (level_inc == MAX_LVL)) begin
            state    <= WIN;
            level    <= level_inc;
            best     <= best_win;
            score    <= {best_win, level_inc};
            game_won <= 1'b1;
            led      <= blink_led;
          end else if (place_valid && place_hit) begin
            level <= level_inc;
            score <= {best, level_inc};
            led   <= {4'h0, level_inc};
          end else if (place_valid) begin
            state     <= LOSE;
            best      <= best_lose;
            score     <= {best_lose, level};
            game_over <= 1'b1;
            led       <= 8'h01;
          end
        end
        WIN: begin
          if (restart_pulse) begin
            state    <= PLAY;
            level    <= '0;
            score    <= {best, 4'h0};
            game_won <= 1'b0;
            led      <= 8'h00;
          end else begin
            led <= blink_led;
          end
        end
        LOSE: begin
          if (restart_pulse) begin
            state     <= PLAY;
            level     <= '0;
            score     <= {best, 4'h0};
            game_over <= 1'b0;
            led       <= 8'h00;
          end
        end
        default: begin
          state     <= PLAY;
          level     <= '0;
          score     <= {best, 4'h0};
          game_over <= 1'b0;
          game_won  <= 1'b0;
          led       <= 8'h00;
        end
      endcase
    end
  end

endmodule
